// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the instruction fetch slice: datapath width, the
//   canonical NOP encoding, the default reset PC, the fetch FSM state type,
//   the instruction queue entry layout, and a word-alignment helper.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned       XLEN             = 32;
   localparam logic [XLEN-1:0]   NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
//   Circular instruction queue of DEPTH {pc, instr} entries.
//
//   Ports
//     clk          in   clock, all state on rising edge
//     rst_n        in   asynchronous active-low reset
//     push_i       in   write push_data_i at the tail
//     push_data_i  in   entry to enqueue
//     pop_i        in   drop the head entry
//     flush_i      in   empty the queue (wins over push and pop)
//     head_o       out  head entry (meaningful only while count_o != 0)
//     count_o      out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  fetch_entry_t               push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output fetch_entry_t               head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             do_push, do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop_i  && (count_q != '0);
   assign do_push = push_i && (count_q < CNT_W'(DEPTH));

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues single-outstanding word requests to
//   instruction memory, queues returned words with their PC, presents the
//   queue head to decode, and handles taken-branch redirects by flushing the
//   queue and discarding any in-flight response.
//
//   Optional build macro: FETCH_PERF_EN adds perf_flushes / perf_stalls.
//
//   Parameters
//     RESET_PC  first fetch address after reset
//     DEPTH     instruction queue entries (2..8)
//
//   Ports
//     clk             in   clock
//     reset           in   asynchronous active-low reset
//     imem_req        out  one-cycle request pulse to instruction memory
//     imem_addr       out  word-aligned request address (0 when no request)
//     imem_rvalid     in   response strobe
//     imem_rdata      in   response instruction word
//     instr_valid     out  queue head valid for decode
//     instr           out  queue head word, NOP when not valid
//     instr_pc        out  queue head PC, 0 when not valid
//     instr_ready     in   decode accepts head
//     redirect_valid  in   taken branch/jump pulse
//     redirect_pc     in   new fetch target (bits [1:0] ignored)
//     perf_flushes    out  (FETCH_PERF_EN) redirect cycle count
//     perf_stalls     out  (FETCH_PERF_EN) cycles decode was ready but starved
// -----------------------------------------------------------------------------
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_flushes,
   output logic [31:0]     perf_stalls
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
      $error("fetch_unit: DEPTH must be in 2..8");
   end

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             push;
   logic             pop;
   logic             slot_free;
   logic             req;

   // No request is ever outstanding in IDLE, so a free slot is simply
   // count < DEPTH and a later push can never find the queue full.
   assign slot_free   = (count < CNT_W'(DEPTH));
   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req        = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!redirect_valid && slot_free) begin
               req     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               // The in-flight word belongs to the old path: drop it now if
               // it is arriving, otherwise wait for it in DISCARD.
               state_d = imem_rvalid ? IDLE : DISCARD;
            end else if (imem_rvalid) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = IDLE;
            end
         end
         DISCARD: begin
            // A response here always answers the stale request, even when a
            // further redirect lands in the same cycle, so leave DISCARD.
            if (imem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) fetch_pc_d = word_align(redirect_pc);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= word_align(RESET_PC);
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Gating with reset keeps the request low while reset is held even though
   // the FSM already sits in IDLE with an empty queue.
   assign imem_req  = req && reset;
   assign imem_addr = imem_req ? fetch_pc_q : '0;

   assign push_entry.pc    = fetch_pc_q;
   assign push_entry.instr = imem_rdata;

   instr_fifo #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign instr    = instr_valid ? head.instr : NOP_INSTR;
   assign instr_pc = instr_valid ? head.pc    : '0;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_flushes_q;
   logic [31:0] perf_stalls_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_flushes_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         if (redirect_valid)               perf_flushes_q <= perf_flushes_q + 32'd1;
         if (instr_ready && !instr_valid)  perf_stalls_q  <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_flushes = perf_flushes_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction queue entries, legal range 2..8.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe, at least 1 cycle after imem_req.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 instr_valid  output  1  queue head holds a valid instruction for decode.
REQ-010 instr  output  32  queue head word; 32'h0000_0013 (NOP) when instr_valid=0.
REQ-011 instr_pc  output  32  PC of queue head; 0 when instr_valid=0.
REQ-012 instr_ready  input  1  decode accepts head; pop when instr_valid & instr_ready.
REQ-013 redirect_valid  input  1  branch/jump taken, one-cycle pulse.
REQ-014 redirect_pc  input  32  new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-015 At most one imem request SHALL be outstanding at any time.
REQ-016 FSM states SHALL be IDLE, WAIT, DISCARD.
REQ-017 IDLE: issue imem_req with imem_addr=fetch_pc when (count + 0) < DEPTH and redirect_valid=0, then go to WAIT; otherwise stay.
REQ-018 WAIT: on imem_rvalid, push {fetch_pc, imem_rdata}, increment fetch_pc by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0), return to IDLE; a request is never issued in the same cycle as a response.
REQ-019 A request is issued only if a queue slot is free counting the outstanding one, so a push SHALL never meet a full queue.
REQ-020 Simultaneous push and pop SHALL both take effect, leaving count unchanged.
REQ-021 redirect_valid SHALL flush the queue (count=0, instr_valid=0 next cycle) and load fetch_pc=redirect_pc regardless of state.
REQ-022 Redirect in WAIT without imem_rvalid in the same cycle: go to DISCARD; the next imem_rvalid SHALL be dropped, then go to IDLE.
REQ-023 Redirect in WAIT with imem_rvalid in the same cycle: response dropped, go to IDLE.
REQ-024 Redirect in DISCARD: update fetch_pc, remain in DISCARD.
REQ-025 Redirect in IDLE: go to IDLE, no request that cycle; first request to redirect_pc on the next cycle.
REQ-026 A pop coinciding with redirect SHALL be accepted by decode but the queue still flushes.
REQ-027 Best-case latency: imem_req to instr_valid = imem response latency + 1 cycle.
REQ-028 imem_rvalid in IDLE (no outstanding request) SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL immediately set state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=0, instr_valid=0, instr=NOP, instr_pc=0.
REQ-030 Reset during WAIT SHALL abandon the outstanding request; the first post-reset rvalid is ignored per REQ-028.
REQ-031 First imem_req SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro FETCH_PERF_EN: when defined, add outputs perf_flushes[31:0] (counts redirect_valid cycles) and perf_stalls[31:0] (counts cycles with instr_ready=1 and instr_valid=0), both reset to 0, wrap at 2^32.
REQ-033 Without FETCH_PERF_EN those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-034 Shared package riscv_pkg SHALL hold fetch_state_t (IDLE/WAIT/DISCARD), XLEN=32, NOP_INSTR=32'h0000_0013, DEFAULT_RESET_PC.
REQ-035 Queue SHALL be sub-module instr_fifo (DEPTH entries of {pc, instr}, count, push, pop, flush, same async active-low reset).

Verification
REQ-036 Reset release, memory latency 1, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; first instr_valid 2 cycles after first imem_req.
REQ-037 instr_ready=0, DEPTH=2 -> exactly 2 requests issued, then imem_req stays 0; count=2; raising instr_ready resumes fetching at 0x8.
REQ-038 Redirect to 0x100 while WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word dropped, next imem_addr=0x100, 0xDEADBEEF never presented.
REQ-039 Redirect to 0x203 coincident with rvalid -> response dropped, next imem_addr=0x200, no DISCARD entry.
REQ-040 fetch_pc=0xFFFF_FFFC -> following imem_addr=0x0000_0000.
REQ-041 With FETCH_PERF_EN, 3 redirects and 5 starved ready cycles -> perf_flushes=3, perf_stalls=5; reset clears both.
